// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared mode encoding and default parameter values
// for the scan_decoder block.
package scan_decoder_pkg;

   typedef enum logic {
      MODE_STATIC = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   localparam int unsigned DEF_SEL_W   = 4;
   localparam int unsigned DEF_NUM_OUT = 16;
   localparam int unsigned DEF_PRESC   = 1000;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: purely combinational index-to-one-hot decoder.
// in_range is low when idx addresses no output bit.
module onehot_dec
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = DEF_SEL_W,
   parameter int unsigned NUM_OUT = DEF_NUM_OUT
) (
   input  logic [SEL_W-1:0]   idx,
   output logic [NUM_OUT-1:0] onehot,
   output logic               in_range
);

   // Bit i is set exactly when idx equals i.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         onehot[i] = (idx == SEL_W'(i));
      end
   end

   // Any set bit means the index was inside 0..NUM_OUT-1.
   always_comb begin
      in_range = |onehot;
   end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with a static mode (decode sel)
// and a scan mode (prescaled walking index). Optional anti-ghosting blank
// in scan mode is enabled by defining SCAN_DECODER_BLANK_EN.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = DEF_SEL_W,
   parameter int unsigned NUM_OUT = DEF_NUM_OUT,
   parameter int unsigned PRESC   = DEF_PRESC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   output logic [NUM_OUT-1:0] out,
   output logic [SEL_W-1:0]   idx,
   output logic               tick,
   output logic               range_err
);

   localparam int unsigned          PRESC_W   = cnt_width(PRESC);
   localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(PRESC - 1);
   localparam logic [SEL_W-1:0]     IDX_MAX   = SEL_W'(NUM_OUT - 1);

   mode_e               mode_cur;
   mode_e               mode_prev_q, mode_prev_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [SEL_W-1:0]    scan_idx_q, scan_idx_d;
   logic                advance;

   logic [NUM_OUT-1:0]  out_q, out_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic                tick_q, tick_d;
   logic                range_err_q, range_err_d;

   logic [SEL_W-1:0]    dec_sel;
   logic [NUM_OUT-1:0]  dec_onehot;
   logic                dec_in_range;

   // Interpret the raw mode pin as the shared mode type.
   always_comb begin
      mode_cur = mode_e'(mode);
   end

   // Prescaler and scan index. mode_prev resets to static, so the first
   // enabled scan edge after reset or after entering scan mode only starts
   // the scan at index 0 and each index is then shown for PRESC cycles.
   always_comb begin
      presc_d     = presc_q;
      scan_idx_d  = scan_idx_q;
      mode_prev_d = mode_prev_q;
      advance     = 1'b0;
      if (enable) begin
         mode_prev_d = mode_cur;
         if (mode_cur == MODE_SCAN) begin
            if (mode_prev_q != MODE_SCAN) begin
               presc_d    = '0;
               scan_idx_d = '0;
            end else if (presc_q == PRESC_MAX) begin
               presc_d    = '0;
               advance    = 1'b1;
               scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + SEL_W'(1);
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end
      end
   end

   // The single decoder sees the upcoming scan index or the static select.
   always_comb begin
      dec_sel = (mode_cur == MODE_SCAN) ? scan_idx_d : sel;
   end

   onehot_dec #(
      .SEL_W   (SEL_W),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .idx      (dec_sel),
      .onehot   (dec_onehot),
      .in_range (dec_in_range)
   );

   // Next output values; disabled cycles blank out but keep idx.
   always_comb begin
      out_d       = '0;
      idx_d       = idx_q;
      tick_d      = 1'b0;
      range_err_d = 1'b0;
      if (enable) begin
         if (mode_cur == MODE_SCAN) begin
            out_d  = dec_onehot;
            idx_d  = scan_idx_d;
            tick_d = advance;
`ifdef SCAN_DECODER_BLANK_EN
            if (presc_d == '0) begin
               out_d = '0;
            end
`endif
         end else begin
            out_d       = dec_onehot;
            idx_d       = dec_in_range ? sel : '0;
            range_err_d = ~dec_in_range;
         end
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         scan_idx_q  <= '0;
         mode_prev_q <= MODE_STATIC;
         out_q       <= '0;
         idx_q       <= '0;
         tick_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         scan_idx_q  <= scan_idx_d;
         mode_prev_q <= mode_prev_d;
         out_q       <= out_d;
         idx_q       <= idx_d;
         tick_q      <= tick_d;
         range_err_q <= range_err_d;
      end
   end

   // Drive ports straight from the registers.
   always_comb begin
      out       = out_q;
      idx       = idx_q;
      tick      = tick_q;
      range_err = range_err_q;
   end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: scoreboard bench for scan_decoder. Two instances share
// the inputs: d4 (SEL_W=3, NUM_OUT=6, PRESC=4) and d1 (same, PRESC=1).
// Expectations follow SCAN_DECODER_BLANK_EN when it is defined.
module tb_scan_decoder;

   typedef struct {
      logic [5:0] out4;
      logic [2:0] idx4;
      logic       tick4;
      logic       err4;
      logic [5:0] out1;
      logic [2:0] idx1;
      logic       tick1;
      logic       err1;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       mode;
   logic [2:0] sel;
   logic [5:0] out4, out1;
   logic [2:0] idx4, idx1;
   logic       tick4, tick1, err4, err1;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sbq[$];

   logic [5:0] st_tab [0:5] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(3), .NUM_OUT(6), .PRESC(4)) d4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
      .out(out4), .idx(idx4), .tick(tick4), .range_err(err4)
   );

   scan_decoder #(.SEL_W(3), .NUM_OUT(6), .PRESC(1)) d1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
      .out(out1), .idx(idx1), .tick(tick1), .range_err(err1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic exp_t zero_e();
      exp_t e;
      e.out4 = '0; e.idx4 = '0; e.tick4 = 1'b0; e.err4 = 1'b0;
      e.out1 = '0; e.idx1 = '0; e.tick1 = 1'b0; e.err1 = 1'b0;
      return e;
   endfunction

   // Static decode expectation, identical for both instances.
   function automatic exp_t static_e(input int s);
      exp_t e = zero_e();
      if (s < 6) begin
         e.out4 = st_tab[s];
         e.idx4 = 3'(s);
      end else begin
         e.err4 = 1'b1;
      end
      e.out1 = e.out4; e.idx1 = e.idx4; e.err1 = e.err4;
      return e;
   endfunction

   // Expectation for the n-th enabled scan edge (n=1 is the start edge).
   function automatic exp_t scan_e(input int n);
      exp_t e = zero_e();
      int   k = ((n - 1) / 4) % 6;
      int   c = (n - 1) % 4;
      e.out4  = st_tab[k];
      e.idx4  = 3'(k);
      e.tick4 = (c == 0) && (n > 1);
      e.idx1  = 3'((n - 1) % 6);
      e.out1  = st_tab[(n - 1) % 6];
      e.tick1 = (n > 1);
`ifdef SCAN_DECODER_BLANK_EN
      if (c == 0) e.out4 = '0;
      e.out1 = '0;
`endif
      return e;
   endfunction

   function automatic exp_t frozen_e(input exp_t s);
      exp_t e = s;
      e.out4 = '0; e.tick4 = 1'b0; e.err4 = 1'b0;
      e.out1 = '0; e.tick1 = 1'b0; e.err1 = 1'b0;
      return e;
   endfunction

   // Called at a negedge: drive inputs, queue the response for the next posedge.
   task automatic step(input logic en_i, input logic mode_i, input logic [2:0] sel_i, input exp_t e);
      enable = en_i;
      mode   = mode_i;
      sel    = sel_i;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compare each presented output against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("d4_out",  32'(out4),  32'(e.out4));
            check("d4_idx",  32'(idx4),  32'(e.idx4));
            check("d4_tick", 32'(tick4), 32'(e.tick4));
            check("d4_err",  32'(err4),  32'(e.err4));
            check("d1_out",  32'(out1),  32'(e.out1));
            check("d1_idx",  32'(idx1),  32'(e.idx1));
            check("d1_tick", 32'(tick1), 32'(e.tick1));
            check("d1_err",  32'(err1),  32'(e.err1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel = '0;
      repeat (2) @(negedge clk);

      // Reset held: outputs stay zero even with active inputs.
      step(1'b1, 1'b0, 3'd3, zero_e());
      rst_n = 1'b1;

      // Static decode of every legal index.
      for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 3'(s), static_e(s));

      // Disabled in static mode: blank, idx holds 5.
      e = zero_e(); e.idx4 = 3'd5; e.idx1 = 3'd5;
      step(1'b0, 1'b0, 3'd2, e);

      // Out-of-range selects.
      step(1'b1, 1'b0, 3'd6, static_e(6));
      step(1'b1, 1'b0, 3'd7, static_e(7));

      // Scan from reset release, past one full wrap, up to index 3.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 38; n++) step(1'b1, 1'b1, 3'd0, scan_e(n));

      // Freeze for 10 cycles, then resume from the held position.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'd0, frozen_e(scan_e(38)));
      for (int n = 39; n <= 42; n++) step(1'b1, 1'b1, 3'd0, scan_e(n));

      // Asynchronous reset mid-cycle while at index 4.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async_d4_out",  32'(out4),  32'd0);
      check("rst_async_d4_idx",  32'(idx4),  32'd0);
      check("rst_async_d4_tick", 32'(tick4), 32'd0);
      check("rst_async_d4_err",  32'(err4),  32'd0);
      check("rst_async_d1_out",  32'(out1),  32'd0);
      check("rst_async_d1_idx",  32'(idx1),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 5; n++) step(1'b1, 1'b1, 3'd0, scan_e(n));

      // Scan -> static follows sel; static -> scan restarts at index 0.
      step(1'b1, 1'b0, 3'd2, static_e(2));
      for (int n = 1; n <= 6; n++) step(1'b1, 1'b1, 3'd0, scan_e(n));

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
